// File: rtl/processor_sequencer_if.sv
// Bus between the self-test sequencer and the 8-bit logic processor it exercises.
// The master side is the sequencer; the slave side is the processor/board.
interface processor_sequencer_if;
    logic       Start;
    logic [7:0] SeedA;
    logic [7:0] SeedB;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       LoadA;
    logic       LoadB;
    logic       Execute;
    logic [7:0] Din;
    logic [2:0] F;
    logic [1:0] R;
    logic       Busy;
    logic       Done;
    logic       Pass;
    logic [3:0] ErrorCnt;
    logic [3:0] FailIdx;

    modport master (
        input  Start, SeedA, SeedB, Aval, Bval,
        output LoadA, LoadB, Execute, Din, F, R, Busy, Done, Pass, ErrorCnt, FailIdx
    );

    modport slave (
        output Start, SeedA, SeedB, Aval, Bval,
        input  LoadA, LoadB, Execute, Din, F, R, Busy, Done, Pass, ErrorCnt, FailIdx
    );
endinterface

// File: rtl/processor_sequencer.sv
// Self-test initiator: loads seeds into the logic processor, runs all eight F/R ops and
// checks Aval/Bval against an internal A/B reference model after every step.
module processor_sequencer #(
    parameter int unsigned PULSE = 2,
    parameter int unsigned GAP   = 2,
    parameter int unsigned WAIT  = 16
) (
    input logic                   Clk,
    input logic                   Reset,
    processor_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        StIdle, StLda, StGapa, StLdb, StGapb, StChkl,
        StSet, StExec, StWait, StChk, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  k_q, k_d;
    logic        accept;

    logic [7:0]  seed_a_q, seed_b_q, seed_a_d, seed_b_d;
    logic [7:0]  model_a_q, model_b_q;
    logic [7:0]  result, new_a, new_b, exp_a, exp_b;
    logic        chk_en, mis_a, mis_b;
    logic [1:0]  add;
    logic [4:0]  err_sum;
    logic [3:0]  err_q, err_d;
    logic [3:0]  fail_idx_q;

    logic        load_a_q, load_b_q, execute_q;
    logic [7:0]  din_q;
    logic [2:0]  f_q;
    logic [1:0]  r_q;
    logic        busy_q, done_q, pass_q;

    // Next-state logic; the cycle counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        k_d     = k_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    accept  = 1'b1;
                    state_d = StLda;
                end
            end
            StLda:  if (cnt_q == 16'(PULSE - 1)) state_d = StGapa;
            StGapa: if (cnt_q == 16'(GAP - 1))   state_d = StLdb;
            StLdb:  if (cnt_q == 16'(PULSE - 1)) state_d = StGapb;
            StGapb: if (cnt_q == 16'(GAP - 1))   state_d = StChkl;
            StChkl: state_d = StSet;
            StSet:  state_d = StExec;
            StExec: if (cnt_q == 16'(PULSE - 1)) state_d = StWait;
            StWait: if (cnt_q == 16'(WAIT - 1))  state_d = StChk;
            StChk: begin
                if (k_q == 3'd7) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = StSet;
                end
            end
            StDone: begin
                // done_q gates restart so Start is ignored while Busy is still high
                if (bus.Start && done_q) begin
                    accept  = 1'b1;
                    state_d = StLda;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept) k_d = 3'd0;
        if (state_d != state_q) cnt_d = 16'd0;
    end

    assign seed_a_d = accept ? bus.SeedA : seed_a_q;
    assign seed_b_d = accept ? bus.SeedB : seed_b_q;

    // Reference model: F and R always equal the op index during CHK.
    always_comb begin
        result = 8'h00;
        unique case (k_q)
            3'd0: result = model_a_q & model_b_q;
            3'd1: result = model_a_q | model_b_q;
            3'd2: result = model_a_q ^ model_b_q;
            3'd3: result = 8'hFF;
            3'd4: result = ~(model_a_q & model_b_q);
            3'd5: result = ~(model_a_q | model_b_q);
            3'd6: result = ~(model_a_q ^ model_b_q);
            3'd7: result = 8'h00;
            default: result = 8'h00;
        endcase
        new_a = model_a_q;
        new_b = model_b_q;
        unique case (k_q[1:0])
            2'b00: ;
            2'b01: new_b = result;
            2'b10: new_a = result;
            2'b11: begin
                new_a = model_b_q;
                new_b = model_a_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        chk_en  = (state_q == StChkl) || (state_q == StChk);
        exp_a   = (state_q == StChkl) ? seed_a_q : new_a;
        exp_b   = (state_q == StChkl) ? seed_b_q : new_b;
        mis_a   = chk_en && (bus.Aval != exp_a);
        mis_b   = chk_en && (bus.Bval != exp_b);
        add     = {1'b0, mis_a} + {1'b0, mis_b};
        err_sum = {1'b0, err_q} + {3'b000, add};
        err_d   = (err_sum > 5'd15) ? 4'd15 : err_sum[3:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            cnt_q      <= 16'd0;
            k_q        <= 3'd0;
            seed_a_q   <= 8'h00;
            seed_b_q   <= 8'h00;
            model_a_q  <= 8'h00;
            model_b_q  <= 8'h00;
            err_q      <= 4'd0;
            fail_idx_q <= 4'd15;
            load_a_q   <= 1'b1;
            load_b_q   <= 1'b1;
            execute_q  <= 1'b1;
            din_q      <= 8'h00;
            f_q        <= 3'd0;
            r_q        <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            seed_a_q <= seed_a_d;
            seed_b_q <= seed_b_d;

            if (accept) begin
                err_q      <= 4'd0;
                fail_idx_q <= 4'd15;
            end else if (chk_en) begin
                err_q     <= err_d;
                model_a_q <= exp_a;
                model_b_q <= exp_b;
                // 15 can never be a real check index, so it doubles as "no failure yet"
                if ((add != 2'd0) && (fail_idx_q == 4'd15)) begin
                    fail_idx_q <= (state_q == StChkl) ? 4'd0 : ({1'b0, k_q} + 4'd1);
                end
            end

            load_a_q  <= (state_d != StLda);
            load_b_q  <= (state_d != StLdb);
            execute_q <= (state_d != StExec);
            din_q     <= (state_d == StLda) ? seed_a_d :
                         (state_d == StLdb) ? seed_b_d : 8'h00;

            if (accept) begin
                f_q <= 3'd0;
                r_q <= 2'd0;
            end else if (state_d == StSet) begin
                f_q <= k_d;
                r_q <= k_d[1:0];
            end

            // Busy stays high through the first DONE cycle so it falls as Done rises.
            busy_q <= !((state_d == StIdle) || ((state_d == StDone) && (state_q == StDone)));
            done_q <= (state_q == StDone) && !accept;
            pass_q <= (state_q == StDone) && !accept && (err_q == 4'd0);
        end
    end

    assign bus.LoadA    = load_a_q;
    assign bus.LoadB    = load_b_q;
    assign bus.Execute  = execute_q;
    assign bus.Din      = din_q;
    assign bus.F        = f_q;
    assign bus.R        = r_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Pass     = pass_q;
    assign bus.ErrorCnt = err_q;
    assign bus.FailIdx  = fail_idx_q;

endmodule

// File: doc/processor_sequencer.md
# processor_sequencer

Synthesizable self-test initiator for the 8-bit logic processor. It drives the processor's active-low LoadA/LoadB/Execute buttons, Din, F and R pins through a fixed load-and-compute script. It samples Aval/Bval after every step, compares them against an internal A/B reference model, and reports a pass/fail verdict and an error count. It sits beside the Processor on the board top level and replaces manual switch and button operation for on-board regression.

## Interface
- PULSE, 2: cycles each active-low button is held low (≥1)
- GAP, 2: idle cycles after each Load pulse (≥1)
- WAIT, 16: cycles after Execute release before sampling results (must cover the processor's full 8-shift compute)
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high; returns the block to IDLE
- Start  in  1  level; sampled only in IDLE
- SeedA  in  8  initial A value; latched when Start is accepted
- SeedB  in  8  initial B value; latched when Start is accepted
- Aval  in  8  processor register A
- Bval  in  8  processor register B
- LoadA  out  1  active-low load-A button
- LoadB  out  1  active-low load-B button
- Execute  out  1  active-low execute button
- Din  out  8  processor data input
- F  out  3  function select
- R  out  2  routing select
- Busy  out  1  script running
- Done  out  1  script complete; held until next accepted Start
- Pass  out  1  valid with Done; 1 iff ErrorCnt==0
- ErrorCnt  out  4  mismatch count, saturates at 15
- FailIdx  out  4  first failing check: 0 = load check, k+1 = op k, 15 = none

## Operation
- Reset values: LoadA=LoadB=Execute=1, Din=0, F=0, R=0, Busy=0, Done=0, Pass=0, ErrorCnt=0, FailIdx=15.
- Function model: F codes are 000 AND, 001 OR, 010 XOR, 011 8'hFF, 100 NAND, 101 NOR, 110 XNOR, 111 8'h00; result = f(A,B).
- Routing model:
  - R=00: no change.
  - R=01: B←result.
  - R=10: A←result.
  - R=11: swap A and B.
- Script: op k (k=0..7) uses F=k, R=k[1:0].
- FSM states:
  - IDLE: Start=1 latches the seeds, clears ErrorCnt, FailIdx, Done and Pass, sets Busy, and moves to LDA.
  - LDA: Din=SeedA, LoadA=0 for PULSE cycles.
  - GAPA: LoadA=1 for GAP cycles.
  - LDB: Din=SeedB, LoadB=0 for PULSE cycles.
  - GAPB: LoadB=1 and Din=0 for GAP cycles.
  - CHKL: one cycle; compares Aval to SeedA and Bval to SeedB; the model is set to the seeds.
  - SET: one cycle; drives F and R for op k.
  - EXEC: Execute=0 for PULSE cycles.
  - WAIT: Execute=1 for WAIT cycles.
  - CHK: one cycle; updates the model, then compares Aval and Bval to the new model. Goes to SET for k+1, or to DONE after k=7.
  - DONE: Busy=0, Done=1, Pass=(ErrorCnt==0). Start=1 restarts (through IDLE behaviour).
- Each mismatching register counts separately, so a check adds 0, 1 or 2 to ErrorCnt.
- FailIdx is written only on the first failing check.
- F and R hold their values from SET through CHK. Din is 0 outside the load states.
- Start while Busy is ignored.
- Reset mid-run returns the block to IDLE with reset values on the next edge, including releasing any held button.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- At most one button is low in any cycle.
- Busy rises the cycle after Start is accepted.
- Cycle counts with defaults:
  - Load phase (LDA..CHKL): 9 cycles.
  - Each op (SET+EXEC+WAIT+CHK): 20 cycles.
  - Done rises 170 cycles after the Start-accept edge.
- Compares sample Aval/Bval in the CHKL/CHK cycle itself.
- ErrorCnt and FailIdx are final when Done rises.
- The processor's own reset is not driven by this block.

## Test plan
- Seeds 8'h33/8'h55 with the behavioural processor:
  - Ops run with F=k, R=k[1:0] for k=0..7.
  - Model trace (A,B): 33/55, 33/77, 44/77, 77/44, 77/44, 77/88, 00/88, 88/00.
  - Final Aval=88, Bval=00, Done=1, Pass=1, ErrorCnt=0, FailIdx=15.
- Same seeds with Bval forced to 8'h00 → 8 mismatches, ErrorCnt=8, FailIdx=0, Pass=0.
- Both Aval and Bval forced to 8'hA5 with seeds 00/00 → ErrorCnt saturates at 15 and does not wrap; FailIdx=0.
- Reset asserted during EXEC of op 3:
  - Next cycle: Execute=1, Busy=0, ErrorCnt=0.
  - A fresh Start then completes in 170 cycles.
- Start pulsed again while Busy → no restart; Done timing unchanged.
- Button monitor run with PULSE=3, GAP=1, WAIT=20:
  - Each low pulse lasts exactly 3 cycles.
  - No two buttons are ever low together.
  - Done rises at 1+3+1+3+1+1 plus 8×(1+3+20+1) cycles after Start-accept.
